// File: rtl/rv32i_pipe3_core.sv
// rv32i_pipe3_core: 3-stage (fetch / decode / execute) in-order RV32I core with E->D forwarding.
module rv32i_pipe3_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  output logic [31:0] instr_addr1,
  input  logic [31:0] instr_rdata1,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_we,
  output logic        data_re,
  input  logic [31:0] data_rdata,
  output logic [31:0] dbg_pc_f,
  output logic [31:0] dbg_instr_f,
  output logic [31:0] dbg_instr_d,
  output logic [31:0] dbg_instr_e,
  output logic [31:0] dbg_result_e,
  output logic        dbg_branch_taken,
  output logic        dbg_stall,
  output logic        dbg_bubble_ex,
  output logic        dbg_fwd_rs1,
  output logic        dbg_fwd_rs2,
  output logic [31:0] dbg_busy_vec
);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [6:0]  OP_AUIPC = 7'h17;
  localparam logic [6:0]  OP_JAL   = 7'h6f;
  localparam logic [6:0]  OP_JALR  = 7'h67;
  localparam logic [6:0]  OP_BR    = 7'h63;
  localparam logic [6:0]  OP_LD    = 7'h03;
  localparam logic [6:0]  OP_ST    = 7'h23;
  localparam logic [6:0]  OP_IMM   = 7'h13;
  localparam logic [6:0]  OP_OP    = 7'h33;

  logic [31:0] pc_q, pc_d, d_ins_q, d_ins_d, d_pc_q, d_pc_d;
  logic [31:0] e_ins_q, e_ins_d, e_pc_q, e_pc_d, e_a_q, e_a_d, e_b_q, e_b_d;
  logic        e_bub_q, e_bub_d, halted_q, halted_d;
  logic [31:0] rf_q [0:31];

  logic [6:0]  d_op, e_op;
  logic [4:0]  d_rs1, d_rs2, e_rd;
  logic [2:0]  f3;
  logic        d_use1, d_use2, e_sys, e_wr, freeze, fwd1, fwd2, hazard, taken, cond, eq, lt, ltu;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, alu, sra, target, addr, ld_val, result, rv1, rv2;
  logic [4:0]  lsh;
  logic [15:0] ld_sh;
  logic        unused_rdata1;

  assign unused_rdata1 = ^instr_rdata1;

  assign d_op   = d_ins_q[6:0];
  assign d_rs1  = d_ins_q[19:15];
  assign d_rs2  = d_ins_q[24:20];
  assign d_use1 = d_op == OP_JALR || d_op == OP_BR || d_op == OP_LD || d_op == OP_ST || d_op == OP_IMM || d_op == OP_OP;
  assign d_use2 = d_op == OP_BR || d_op == OP_ST || d_op == OP_OP;

  assign e_op  = e_ins_q[6:0];
  assign e_rd  = e_ins_q[11:7];
  assign f3    = e_ins_q[14:12];
  assign imm_i = {{20{e_ins_q[31]}}, e_ins_q[31:20]};
  assign imm_s = {{20{e_ins_q[31]}}, e_ins_q[31:25], e_ins_q[11:7]};
  assign imm_b = {{19{e_ins_q[31]}}, e_ins_q[31], e_ins_q[7], e_ins_q[30:25], e_ins_q[11:8], 1'b0};
  assign imm_u = {e_ins_q[31:12], 12'b0};
  assign imm_j = {{11{e_ins_q[31]}}, e_ins_q[31], e_ins_q[19:12], e_ins_q[20], e_ins_q[30:21], 1'b0};
  assign e_sys = e_ins_q == 32'h0000_0073 || e_ins_q == 32'h0010_0073;
  assign e_wr  = (e_op == OP_LUI || e_op == OP_AUIPC || e_op == OP_JAL || e_op == OP_JALR ||
                  e_op == OP_LD || e_op == OP_IMM || e_op == OP_OP) && e_rd != 5'd0;
  assign freeze = halted_q || e_sys;

  assign alu_b = e_op == OP_OP ? e_b_q : imm_i;
  assign sra   = $signed(e_a_q) >>> alu_b[4:0];
  assign alu   = f3 == 3'd0 ? ((e_op == OP_OP && e_ins_q[30]) ? e_a_q - alu_b : e_a_q + alu_b) :
                 f3 == 3'd1 ? e_a_q << alu_b[4:0] :
                 f3 == 3'd2 ? {31'b0, $signed(e_a_q) < $signed(alu_b)} :
                 f3 == 3'd3 ? {31'b0, e_a_q < alu_b} :
                 f3 == 3'd4 ? e_a_q ^ alu_b :
                 f3 == 3'd5 ? (e_ins_q[30] ? sra : e_a_q >> alu_b[4:0]) :
                 f3 == 3'd6 ? e_a_q | alu_b : e_a_q & alu_b;

  assign eq     = e_a_q == e_b_q;
  assign lt     = $signed(e_a_q) < $signed(e_b_q);
  assign ltu    = e_a_q < e_b_q;
  assign cond   = f3 == 3'd0 ? eq : f3 == 3'd1 ? !eq : f3 == 3'd4 ? lt : f3 == 3'd5 ? !lt :
                  f3 == 3'd6 ? ltu : f3 == 3'd7 ? !ltu : 1'b0;
  assign taken  = e_op == OP_JAL || e_op == OP_JALR || (e_op == OP_BR && cond);
  assign target = e_op == OP_JAL ? e_pc_q + imm_j : e_op == OP_JALR ? (e_a_q + imm_i) & ~32'h1 : e_pc_q + imm_b;

  assign addr   = e_a_q + (e_op == OP_ST ? imm_s : imm_i);
  assign lsh    = {addr[1:0], 3'b0};
  assign ld_sh  = 16'(data_rdata >> lsh);
  assign ld_val = f3 == 3'd0 ? {{24{ld_sh[7]}}, ld_sh[7:0]} :
                  f3 == 3'd1 ? {{16{ld_sh[15]}}, ld_sh} :
                  f3 == 3'd4 ? {24'b0, ld_sh[7:0]} :
                  f3 == 3'd5 ? {16'b0, ld_sh} : data_rdata;
  assign result = e_op == OP_LUI ? imm_u : e_op == OP_AUIPC ? e_pc_q + imm_u :
                  (e_op == OP_JAL || e_op == OP_JALR) ? e_pc_q + 32'd4 : e_op == OP_LD ? ld_val : alu;

  // E's result feeds D directly; a load in E also forces a stall so the loaded value is never consumed early.
  assign fwd1   = e_wr && e_rd == d_rs1;
  assign fwd2   = e_wr && e_rd == d_rs2;
  assign rv1    = fwd1 ? result : d_rs1 == 5'd0 ? 32'd0 : rf_q[d_rs1];
  assign rv2    = fwd2 ? result : d_rs2 == 5'd0 ? 32'd0 : rf_q[d_rs2];
  assign hazard = e_op == OP_LD && ((d_use1 && fwd1) || (d_use2 && fwd2));

  always_comb begin
    pc_d = pc_q + 32'd4;
    d_ins_d = instr_rdata;
    d_pc_d = pc_q;
    e_ins_d = d_ins_q;
    e_pc_d = d_pc_q;
    e_a_d = rv1;
    e_b_d = rv2;
    e_bub_d = 1'b0;
    halted_d = halted_q || e_sys;
    if (rst) begin
      pc_d = RESET_PC;
      d_ins_d = NOP;
      e_ins_d = NOP;
      halted_d = 1'b0;
    end else if (freeze) begin
      pc_d = pc_q;
      d_ins_d = d_ins_q;
      d_pc_d = d_pc_q;
      e_ins_d = e_ins_q;
      e_pc_d = e_pc_q;
      e_a_d = e_a_q;
      e_b_d = e_b_q;
      e_bub_d = e_bub_q;
    end else if (taken) begin
      pc_d = target;
      d_ins_d = NOP;
      e_ins_d = NOP;
    end else if (hazard) begin
      pc_d = pc_q;
      d_ins_d = d_ins_q;
      d_pc_d = d_pc_q;
      e_ins_d = NOP;
      e_bub_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    d_ins_q <= d_ins_d;
    d_pc_q <= d_pc_d;
    e_ins_q <= e_ins_d;
    e_pc_q <= e_pc_d;
    e_a_q <= e_a_d;
    e_b_q <= e_b_d;
    e_bub_q <= e_bub_d;
    halted_q <= halted_d;
    if (e_wr && !rst) rf_q[e_rd] <= result;
  end

  assign instr_addr       = pc_q;
  assign instr_addr1      = pc_q + 32'd4;
  assign data_addr        = addr;
  assign data_wdata       = e_b_q << lsh;
  assign data_we          = (e_op != OP_ST || rst) ? 4'h0 : f3 == 3'd2 ? 4'hf :
                            f3 == 3'd1 ? 4'b0011 << addr[1:0] : f3 == 3'd0 ? 4'b0001 << addr[1:0] : 4'h0;
  assign data_re          = e_op == OP_LD && !rst;
  assign dbg_pc_f         = pc_q;
  assign dbg_instr_f      = instr_rdata;
  assign dbg_instr_d      = d_ins_q;
  assign dbg_instr_e      = e_ins_q;
  assign dbg_result_e     = result;
  assign dbg_branch_taken = taken && !rst;
  assign dbg_stall        = hazard && !rst;
  assign dbg_bubble_ex    = e_bub_q && !rst;
  assign dbg_fwd_rs1      = fwd1 && !rst;
  assign dbg_fwd_rs2      = fwd2 && !rst;
  assign dbg_busy_vec     = (e_wr && !rst) ? 32'd1 << e_rd : 32'd0;
endmodule

// File: tb/tb_rv32i_pipe3_core.sv
// tb_rv32i_pipe3_core: directed program with write-back / store / redirect scoreboards.
module tb_rv32i_pipe3_core;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_addr, instr_rdata, instr_addr1, instr_rdata1, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_we;
  logic        data_re;
  logic [31:0] dbg_pc_f, dbg_instr_f, dbg_instr_d, dbg_instr_e, dbg_result_e, dbg_busy_vec;
  logic        dbg_branch_taken, dbg_stall, dbg_bubble_ex, dbg_fwd_rs1, dbg_fwd_rs2;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [36:0] wq [$];
  logic [67:0] sq [$];
  logic [31:0] tq [$];
  logic [31:0] addi2;
  logic        tk_pend = 1'b0;
  int          wp = 0;
  int          n_chk = 0, n_fail = 0;
  int          stall_cnt = 0, bub_cnt = 0, taken_cnt = 0, fwd_seen = 0;

  always #5 clk = ~clk;

  assign instr_rdata  = imem[instr_addr[9:2]];
  assign instr_rdata1 = imem[instr_addr1[9:2]];
  assign data_rdata   = dmem[data_addr[9:2]];

  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (data_we[b]) dmem[data_addr[9:2]][8*b +: 8] <= data_wdata[8*b +: 8];

  rv32i_pipe3_core dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata),
    .instr_addr1(instr_addr1), .instr_rdata1(instr_rdata1),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_re(data_re),
    .data_rdata(data_rdata),
    .dbg_pc_f(dbg_pc_f), .dbg_instr_f(dbg_instr_f), .dbg_instr_d(dbg_instr_d), .dbg_instr_e(dbg_instr_e),
    .dbg_result_e(dbg_result_e), .dbg_branch_taken(dbg_branch_taken), .dbg_stall(dbg_stall),
    .dbg_bubble_ex(dbg_bubble_ex), .dbg_fwd_rs1(dbg_fwd_rs1), .dbg_fwd_rs2(dbg_fwd_rs2),
    .dbg_busy_vec(dbg_busy_vec)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic int onehot_idx(logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic emit(input logic [31:0] ins);
    imem[wp >> 2] = ins;
    wp += 4;
  endtask
  task automatic expw(input logic [4:0] rd, input logic [31:0] v);
    wq.push_back({rd, v});
  endtask
  task automatic exps(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    sq.push_back({a, we, d});
  endtask

  // Monitor: every E write-back, store and redirect is matched against the expectation queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (|dbg_busy_vec) begin
        if (wq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wb_extra: x%0d <= %h with nothing expected", onehot_idx(dbg_busy_vec), dbg_result_e);
        end else begin
          logic [36:0] e;
          e = wq.pop_front();
          chk("wb_rd", onehot_idx(dbg_busy_vec), {27'd0, e[36:32]});
          chk("wb_val", dbg_result_e, e[31:0]);
        end
      end
      if (|data_we) begin
        if (sq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL st_extra: addr %h we %b data %h with nothing expected", data_addr, data_we, data_wdata);
        end else begin
          logic [67:0] s;
          s = sq.pop_front();
          chk("st_addr", data_addr, s[67:36]);
          chk("st_we", {28'd0, data_we}, {28'd0, s[35:32]});
          chk("st_data", data_wdata, s[31:0]);
        end
      end
      if (tk_pend) begin
        if (tq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL redirect_extra: pc %h with no redirect expected", dbg_pc_f);
        end else chk("redirect_pc", dbg_pc_f, tq.pop_front());
      end
      tk_pend = dbg_branch_taken;
      stall_cnt += int'(dbg_stall);
      bub_cnt += int'(dbg_bubble_ex);
      taken_cnt += int'(dbg_branch_taken);
      if (dbg_instr_d == addi2) begin
        fwd_seen++;
        chk("fwd_rs1", {31'd0, dbg_fwd_rs1}, 32'd1);
        chk("fwd_nostall", {31'd0, dbg_stall}, 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    addi2 = enc_i(12'd7, 5'd1, 3'd0, 5'd2, 7'h13);
    emit(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));        expw(5'd1, 32'd5);
    emit(addi2);                                         expw(5'd2, 32'd12);
    emit(enc_s(12'h100, 5'd2, 5'd0, 3'd2));              exps(32'h100, 4'hf, 32'd12);
    emit(enc_i(12'h100, 5'd0, 3'd2, 5'd3, 7'h03));       expw(5'd3, 32'd12);
    emit({7'h0, 5'd3, 5'd3, 3'd0, 5'd4, 7'h33});         expw(5'd4, 32'd24);
    emit({20'h80008, 5'd5, 7'h37});                      expw(5'd5, 32'h8000_8000);
    emit(enc_i(12'h0ff, 5'd5, 3'd0, 5'd5, 7'h13));       expw(5'd5, 32'h8000_80ff);
    emit(enc_s(12'h104, 5'd5, 5'd0, 3'd2));              exps(32'h104, 4'hf, 32'h8000_80ff);
    emit(enc_i(12'h104, 5'd0, 3'd0, 5'd6, 7'h03));       expw(5'd6, 32'hffff_ffff);
    emit(enc_i(12'h104, 5'd0, 3'd4, 5'd7, 7'h03));       expw(5'd7, 32'h0000_00ff);
    emit(enc_i(12'h106, 5'd0, 3'd1, 5'd8, 7'h03));       expw(5'd8, 32'hffff_8000);
    emit(enc_s(12'h107, 5'd1, 5'd0, 3'd0));              exps(32'h107, 4'b1000, 32'h0500_0000);
    emit(enc_i(12'h104, 5'd0, 3'd2, 5'd9, 7'h03));       expw(5'd9, 32'h0500_80ff);
    emit(enc_b(13'd12, 5'd0, 5'd0, 3'd0));               tq.push_back(32'h40);
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd11, 7'h13));
    emit(enc_i(12'd42, 5'd0, 3'd0, 5'd12, 7'h13));       expw(5'd12, 32'd42);
    emit(enc_j(21'd8, 5'd13));                           expw(5'd13, 32'h48); tq.push_back(32'h4c);
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd14, 7'h13));
    emit(EBREAK);
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd15, 7'h13));

    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_we", {28'd0, data_we}, 32'd0);
      chk("rst_flags", {26'd0, data_re, dbg_branch_taken, dbg_stall, dbg_bubble_ex, dbg_fwd_rs1, dbg_fwd_rs2}, 32'd0);
      chk("rst_busy", dbg_busy_vec, 32'd0);
    end
    rst = 1'b0;
    chk("pc0", dbg_pc_f, 32'h0);
    @(negedge clk);
    chk("pc1", dbg_pc_f, 32'h4);
    @(negedge clk);
    chk("pc2", dbg_pc_f, 32'h8);

    for (int i = 0; i < 300 && dbg_instr_e !== EBREAK; i++) @(negedge clk);
    chk("halt_reach", dbg_instr_e, EBREAK);
    repeat (10) @(negedge clk);
    chk("halt_e", dbg_instr_e, EBREAK);
    chk("halt_pc", dbg_pc_f, 32'h54);
    chk("halt_we", {28'd0, data_we}, 32'd0);
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("sq_left", 32'(sq.size()), 32'd0);
    chk("tq_left", 32'(tq.size()), 32'd0);
    chk("stall_cnt", stall_cnt, 32'd1);
    chk("bubble_cnt", bub_cnt, 32'd1);
    chk("taken_cnt", taken_cnt, 32'd2);
    chk("fwd_seen", fwd_seen, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
